exp_driver: RTL

Host-side initiator for the `exponential` accelerator. It accepts x operands over a valid/ready request channel and runs the accelerator's start/done protocol. It captures `intpart`/`fracpart` and returns them over a valid/ready response channel, with a watchdog that flags an accelerator that never asserts done. It sits between the system-side producer/consumer and one `exponential` instance, and it owns that instance's `start` and `x` inputs.

---
 rtl/exp_pkg.sv | 26 ++
 rtl/exp_timeout_counter.sv | 39 +++
 rtl/exp_driver.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/exp_pkg.sv
// Shared definitions for the exponential-accelerator host driver:
// state encoding, datapath widths, parameter defaults and result packing.
package exp_pkg;

  localparam int X_W    = 16;
  localparam int INT_W  = 2;
  localparam int FRAC_W = 16;
  localparam int RES_W  = 18;

  localparam int DEF_START_CYCLES = 2;
  localparam int DEF_TIMEOUT      = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } exp_drv_state_t;

  // Result is kept as one 2.16 word so the capture and hold logic stays in one register.
  function automatic logic [RES_W-1:0] pack_res(input logic [INT_W-1:0]  ip,
                                                input logic [FRAC_W-1:0] fp);
    return {ip, fp};
  endfunction

endpackage

// File: rtl/exp_timeout_counter.sv
// Clearable, enabled up-counter used as the WAIT-state watchdog; expired is
// high once the count has reached TIMEOUT-1, and the count saturates there.
module exp_timeout_counter
  import exp_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cnt_r;
  logic             expired_s;

  assign expired_s = (cnt_r == CNT_LAST);
  assign expired   = expired_s;

  // Watchdog count register: clear has priority, increments stop at the last value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= CNT_ZERO;
    end else if (clr) begin
      cnt_r <= CNT_ZERO;
    end else if (en && !expired_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/exp_driver.sv
// Host-side initiator for the exponential accelerator: request channel in,
// start/done handshake to the accelerator, watchdog, response channel out.
module exp_driver
  import exp_pkg::*;
#(
  parameter int START_CYCLES = DEF_START_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [X_W-1:0]    req_x,
  output logic              acc_start,
  output logic [X_W-1:0]    acc_x,
  input  logic              acc_done,
  input  logic [INT_W-1:0]  acc_intpart,
  input  logic [FRAC_W-1:0] acc_fracpart,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [INT_W-1:0]  rsp_intpart,
  output logic [FRAC_W-1:0] rsp_fracpart,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int SCNT_W = $clog2(START_CYCLES + 1);
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(START_CYCLES);
  localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
  localparam logic [SCNT_W-1:0] SCNT_ZERO = SCNT_W'(0);

  exp_drv_state_t    state_r, state_s;
  logic [SCNT_W-1:0] scnt_r, scnt_s;
  logic              acc_start_r, acc_start_s;
  logic [X_W-1:0]    acc_x_r, acc_x_s;
  logic [RES_W-1:0]  res_r, res_s;
  logic              timeout_r, timeout_s;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic              busy_r;
  logic              wd_clr_s;
  logic              wd_en_s;
  logic              wd_expired_s;

  exp_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .expired (wd_expired_s)
  );

  // Next-state and datapath-update logic for the start/done sequencer.
  always_comb begin
    state_s     = state_r;
    scnt_s      = scnt_r;
    acc_start_s = 1'b0;
    acc_x_s     = acc_x_r;
    res_s       = res_r;
    timeout_s   = timeout_r;
    wd_clr_s    = 1'b1;
    wd_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          state_s = ST_START;
          acc_x_s = req_x;
          scnt_s  = SCNT_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        // One setup cycle with x stable precedes the start pulse.
        if (scnt_r != SCNT_ZERO) begin
          acc_start_s = 1'b1;
          scnt_s      = scnt_r - SCNT_ONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wd_clr_s = 1'b0;
        // Done is checked before expiry so a same-cycle done still returns data.
        if (acc_done) begin
          res_s     = pack_res(acc_intpart, acc_fracpart);
          timeout_s = 1'b0;
          state_s   = ST_RESP;
        end else if (wd_expired_s) begin
          res_s     = RES_W'(0);
          timeout_s = 1'b1;
          state_s   = ST_RESP;
        end else begin
          wd_en_s = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_valid_r && rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update; handshake flags are derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      scnt_r      <= SCNT_ZERO;
      acc_start_r <= 1'b0;
      acc_x_r     <= {X_W{1'b0}};
      res_r       <= {RES_W{1'b0}};
      timeout_r   <= 1'b0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      scnt_r      <= scnt_s;
      acc_start_r <= acc_start_s;
      acc_x_r     <= acc_x_s;
      res_r       <= res_s;
      timeout_r   <= timeout_s;
      req_ready_r <= (state_s == ST_IDLE);
      rsp_valid_r <= (state_s == ST_RESP);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  assign req_ready    = req_ready_r;
  assign acc_start    = acc_start_r;
  assign acc_x        = acc_x_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_intpart  = res_r[RES_W-1:FRAC_W];
  assign rsp_fracpart = res_r[FRAC_W-1:0];
  assign rsp_timeout  = timeout_r;
  assign busy         = busy_r;

endmodule
